// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle 16-bit core: opcodes, FSM states, PC source and ALU codes.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LW   = 4'h9;
   localparam logic [3:0] OP_SW   = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_ILL  = 4'hD;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_REL = 2'd1;
   localparam logic [1:0] PC_ABS = 2'd2;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;

   function automatic logic is_rtype(input logic [3:0] op);
      return ~op[3];
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; strobes decode from the registered state,
// memory handshakes complete combinationally on mem_ready, and a wait counter faults stuck accesses.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int OPW    = 4,
   parameter int MEM_TO = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        mem_ready,
   input  logic        zero_flag,
   output logic        imem_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        rf_we,
   output logic        wb_sel,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  state
);

   localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q;
   logic [3:0]     op4;
   logic [CW-1:0]  wait_cnt;
   logic           fault_q, fault_set, waiting, timed_out;

   logic       imem_req_c, ir_we_c, pc_we_c, alu_src_imm_c;
   logic       dmem_req_c, dmem_we_c, rf_we_c, wb_sel_c;
   logic [1:0] pc_src_c;
   logic [3:0] alu_op_c;

   assign op4       = 4'(op_q);
   assign timed_out = (MEM_TO > 0) && (wait_cnt == CW'(MEM_TO - 1));

   always_comb begin
      state_d       = state_q;
      imem_req_c    = 1'b0;
      ir_we_c       = 1'b0;
      pc_we_c       = 1'b0;
      pc_src_c      = PC_INC;
      alu_op_c      = ALU_ADD;
      alu_src_imm_c = 1'b0;
      dmem_req_c    = 1'b0;
      dmem_we_c     = 1'b0;
      rf_we_c       = 1'b0;
      wb_sel_c      = 1'b0;
      fault_set     = 1'b0;
      waiting       = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (mem_ready) begin
               ir_we_c = 1'b1;
               pc_we_c = 1'b1;
               state_d = S_DECODE;
            end else begin
               waiting = 1'b1;
               if (timed_out) begin
                  state_d   = S_HALT;
                  fault_set = 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (op4 == OP_HLT) begin
               state_d = S_HALT;
            end else if (op4 == OP_ILL) begin
               state_d   = S_HALT;
               fault_set = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_rtype(op4)) begin
               alu_op_c = op4;
               state_d  = S_WB;
            end else begin
               case (op4)
                  OP_ADDI: begin
                     alu_src_imm_c = 1'b1;
                     state_d       = S_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_src_imm_c = 1'b1;
                     state_d       = S_MEM;
                  end
                  OP_BEQ: begin
                     alu_op_c = ALU_SUB;
                     if (zero_flag) begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_REL;
                     end
                  end
                  OP_JMP: begin
                     pc_we_c  = 1'b1;
                     pc_src_c = PC_ABS;
                  end
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (op4 == OP_SW);
            if (mem_ready) begin
               state_d = (op4 == OP_LW) ? S_WB : S_FETCH;
            end else begin
               waiting = 1'b1;
               if (timed_out) begin
                  state_d   = S_HALT;
                  fault_set = 1'b1;
               end
            end
         end
         S_WB: begin
            rf_we_c  = 1'b1;
            wb_sel_c = (op4 == OP_LW);
            state_d  = S_FETCH;
         end
         S_HALT:  ;
         default: state_d = S_FETCH;
      endcase
   end

   // Wait count restarts whenever the access completes or the state is left.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         op_q     <= OPW'(OP_NOP);
         wait_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         if (ir_we_c) op_q <= instr[15 -: OPW];
         wait_cnt <= (waiting && state_d == state_q) ? wait_cnt + 1'b1 : '0;
         if (fault_set) fault_q <= 1'b1;
      end
   end

   assign imem_req    = imem_req_c & ~rst;
   assign ir_we       = ir_we_c & ~rst;
   assign pc_we       = pc_we_c & ~rst;
   assign pc_src      = rst ? PC_INC : pc_src_c;
   assign alu_op      = rst ? ALU_ADD : alu_op_c;
   assign alu_src_imm = alu_src_imm_c & ~rst;
   assign dmem_req    = dmem_req_c & ~rst;
   assign dmem_we     = dmem_we_c & ~rst;
   assign rf_we       = rf_we_c & ~rst;
   assign wb_sel      = wb_sel_c & ~rst;
   assign halted      = (state_q == S_HALT) & ~rst;
   assign fault       = fault_q & ~rst;
   assign state       = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized instruction streams checked cycle-by-cycle against a phase-level model.
module tb_multicycle_ctrl;

   localparam int TO = 15;

   logic        clk, rst, mem_ready, zero_flag;
   logic [15:0] instr;
   logic        imem_req, ir_we, pc_we, alu_src_imm, dmem_req, dmem_we, rf_we, wb_sel, halted, fault;
   logic [1:0]  pc_src;
   logic [3:0]  alu_op;
   logic [2:0]  state;

   typedef struct packed {
      logic [2:0] st;
      logic       imem_req, ir_we, pc_we;
      logic [1:0] pc_src;
      logic [3:0] alu_op;
      logic       alu_src_imm, dmem_req, dmem_we, rf_we, wb_sel, halted, fault;
   } obs_t;

   typedef struct {
      obs_t o;
      logic rdy;
      logic z;
   } step_t;

   step_t q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    ops[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14};

   multicycle_ctrl #(.OPW(4), .MEM_TO(TO)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero_flag(zero_flag),
      .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
      .alu_src_imm(alu_src_imm), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
      .wb_sel(wb_sel), .halted(halted), .fault(fault), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic obs_t blank(input int st);
      obs_t o;
      o    = '0;
      o.st = 3'(st);
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o = {state, imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
           dmem_req, dmem_we, rf_we, wb_sel, halted, fault};
      return o;
   endfunction

   task automatic add_step(input obs_t o, input logic rdy, input logic z);
      step_t s;
      s.o = o; s.rdy = rdy; s.z = z;
      q.push_back(s);
   endtask

   task automatic add_halt(input logic flt, input int n);
      obs_t o;
      o = blank(5); o.halted = 1'b1; o.fault = flt;
      for (int i = 0; i < n; i++) add_step(o, rnd(), rnd());
   endtask

   // One memory access with w wait cycles; w >= TO means the access times out.
   task automatic add_access(input int st, input logic is_fetch, input logic we, input int w,
                             output bit timed);
      obs_t o;
      int   nw;
      o = blank(st);
      if (is_fetch) o.imem_req = 1'b1;
      else begin o.dmem_req = 1'b1; o.dmem_we = we; end
      nw = (w >= TO) ? TO : w;
      for (int i = 0; i < nw; i++) add_step(o, 1'b0, rnd());
      timed = (w >= TO);
      if (timed) begin
         add_halt(1'b1, 4);
      end else begin
         if (is_fetch) begin o.ir_we = 1'b1; o.pc_we = 1'b1; end
         add_step(o, 1'b1, rnd());
      end
   endtask

   task automatic build(input logic [15:0] ins, input int fw, input int mw, input logic z,
                        output bit stopped);
      logic [3:0] op;
      obs_t       o;
      bit         t;
      instr   = ins;
      op      = ins[15:12];
      stopped = 1'b1;
      add_access(0, 1'b1, 1'b0, fw, t);
      if (t) return;
      add_step(blank(1), rnd(), rnd());
      if (op == 4'hF) begin add_halt(1'b0, 20); return; end
      if (op == 4'hD) begin add_halt(1'b1, 4); return; end
      o = blank(2);
      if (op < 4'h8) o.alu_op = op;
      else if (op == 4'h8 || op == 4'h9 || op == 4'hA) o.alu_src_imm = 1'b1;
      else if (op == 4'hB) begin
         o.alu_op = 4'h1;
         if (z) begin o.pc_we = 1'b1; o.pc_src = 2'd1; end
      end else if (op == 4'hC) begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
      add_step(o, rnd(), (op == 4'hB) ? z : rnd());
      if (op == 4'h9 || op == 4'hA) begin
         add_access(3, 1'b0, op == 4'hA, mw, t);
         if (t) return;
      end
      if (op <= 4'h9) begin
         o = blank(4); o.rf_we = 1'b1; o.wb_sel = (op == 4'h9);
         add_step(o, rnd(), rnd());
      end
      stopped = 1'b0;
   endtask

   // Plays up to 'limit' queued cycles (-1 = all), then discards the rest.
   task automatic run_q(input string tag, input int limit);
      step_t s;
      obs_t  got;
      int    i;
      i = 0;
      while (q.size() > 0 && (limit < 0 || i < limit)) begin
         s = q.pop_front();
         mem_ready = s.rdy;
         zero_flag = s.z;
         #3;
         got = observe();
         n_cmp++;
         assert (got === s.o) else begin
            n_bad++;
            $error("FAIL %s cyc %0d: got %h want %h", tag, i, got, s.o);
         end
         @(posedge clk); #1;
         i++;
      end
      q.delete();
   endtask

   task automatic do_reset(input string tag, input int cycles);
      obs_t got;
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         mem_ready = rnd();
         zero_flag = rnd();
         @(posedge clk); #1;
         got = observe();
         n_cmp++;
         assert (got === obs_t'('0)) else begin
            n_bad++;
            $error("FAIL %s rst cyc %0d: got %h want 0", tag, i, got);
         end
      end
      rst = 1'b0;
   endtask

   task automatic one(input string tag, input logic [15:0] ins, input int fw, input int mw,
                      input logic z);
      bit st;
      build(ins, fw, mw, z, st);
      run_q(tag, -1);
      if (st) do_reset({tag, "_rst"}, 2);
   endtask

   initial begin
      bit st;
      rst = 1'b1; mem_ready = 1'b0; zero_flag = 1'b0; instr = 16'h0;
      @(posedge clk); #1;
      do_reset("reset", 3);

      one("addi",     16'h8105, 0, 0, 1'b0);
      one("lw_wait2", 16'h9203, 0, 2, 1'b0);
      one("beq_z1",   16'hB0FC, 0, 0, 1'b1);
      one("beq_z0",   16'hB0FC, 0, 0, 1'b0);
      one("jmp",      16'hC123, 1, 0, 1'b0);
      one("nop",      16'hE000, 0, 0, 1'b0);
      one("sw",       16'hA456, 2, 1, 1'b0);
      one("rtype",    16'h7ABC, 0, 0, 1'b0);
      one("sw_near",  16'hA001, 0, TO - 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         logic [3:0] op;
         op = 4'(ops[$urandom_range(0, 13)]);
         one("rand", {op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
      end

      one("hlt",         16'hF000, 0, 0, 1'b0);
      one("illegal",     16'hD000, 0, 0, 1'b0);
      one("fetch_to",    16'h8105, TO + 3, 0, 1'b0);
      one("fetch_to_ex", 16'h1234, TO, 0, 1'b0);
      one("mem_to",      16'h9001, 0, TO + 5, 1'b0);

      build(16'hA777, 0, 6, 1'b0, st);
      run_q("sw_abort", 5);
      do_reset("sw_abort_rst", 2);
      one("after_rst", 16'h8105, 0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
